uart_tx_cfg: RTL and testbench

Parametrised UART transmitter for the FPGA demo designs, replacing the fixed 8N1 transmitter and its separate free-running baud pulse generator. It contains its own frame-aligned baud divider, a configurable frame format (data bits, parity, stop bits) and a transmit FIFO behind a valid/ready input. It sits between any byte producer in the fabric and the board's UART TX pin.

---
 rtl/uart_tx_cfg.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with a configurable frame format, its own
// frame-aligned baud divider and a transmit FIFO behind a valid/ready input.
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BW  = 4;

  // Reject configurations the datapath cannot represent.
  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: clock-to-baud ratio must give at least 2 cycles per bit");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_cfg: DEPTH must be a power of two, at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state, state_d;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [PW-1:0]          count;
  logic                   full, empty, push, pop;
  logic [DATA_BITS-1:0]   head;
  logic                   head_par;
  logic [DATA_BITS-1:0]   shreg, shreg_d;
  logic                   par_bit, par_bit_d;
  logic [CW-1:0]          baud_cnt, baud_d;
  logic [BW-1:0]          bit_cnt, bit_d;
  logic                   tick;
  logic                   tx_d;

  // FIFO status comes only from the registered pointers, so in_ready never
  // depends combinationally on this cycle's pop.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == PW'(DEPTH));
  assign empty      = (wr_ptr == rd_ptr);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign fifo_count = count;
  assign busy       = (state != ST_IDLE);

  // Parity of the word about to be loaded: odd makes the total count of ones odd.
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_par = (PARITY == 1) ? ~(^head) : (^head);
  assign tick     = (baud_cnt == CW'(DIV - 1));

  // Storage array; written on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers; reset flushes everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Frame state, counters, shift register and the registered line output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      par_bit  <= par_bit_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      tx       <= tx_d;
    end
  end

  // Next-state logic; tx is derived from the next state so the line changes
  // on the same edge the FSM enters each bit.
  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    par_bit_d = par_bit;
    baud_d    = '0;
    bit_d     = bit_cnt;
    pop       = 1'b0;
    tx_d      = 1'b1;

    if (state != ST_IDLE) begin
      baud_d = tick ? '0 : baud_cnt + CW'(1);
    end

    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shreg_d   = head;
          par_bit_d = head_par;
          bit_d     = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_cnt + BW'(1);
            shreg_d = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!empty) begin
              pop       = 1'b1;
              shreg_d   = head;
              par_bit_d = head_par;
              state_d   = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_bit_d;
      default:   tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: drives four transmitter configurations and decodes their
// lines with a mid-bit sampling receiver, comparing against expected frames.
module tb_uart_tx_cfg;

  localparam int DIV = (25_000_000 + 115200 / 2) / 115200;

  typedef struct {
    logic [8:0] data;
    logic       par;
    logic       ok;
  } rx_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [3:0] v;
  wire  [3:0] rdy, tx_w, busy_w;
  wire  [4:0] cnt0, cnt1, cnt2, cnt3;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rx_t rx0_q[$], rx1_q[$], rx2_q[$], rx3_q[$];

  int   busy_run[4]  = '{default: 0};
  int   busy_last[4] = '{default: 0};
  int   busy_rise[4] = '{default: 0};
  int   busy_done[4] = '{default: 0};
  logic [3:0] busy_prev = '0;

  always #5 clk = ~clk;

  uart_tx_cfg u0 (.clk(clk), .rst(rst), .in_data(d0), .in_valid(v[0]), .in_ready(rdy[0]),
                  .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt0));
  uart_tx_cfg #(.PARITY(2)) u1 (.clk(clk), .rst(rst), .in_data(d1), .in_valid(v[1]),
                  .in_ready(rdy[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt1));
  uart_tx_cfg #(.PARITY(1)) u2 (.clk(clk), .rst(rst), .in_data(d2), .in_valid(v[2]),
                  .in_ready(rdy[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt2));
  uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .in_data(d3),
                  .in_valid(v[3]), .in_ready(rdy[3]), .tx(tx_w[3]), .busy(busy_w[3]),
                  .fifo_count(cnt3));

  // Measures how long busy stays high in each contiguous run, per instance.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (busy_w[i] === 1'b1) begin
        busy_run[i] <= busy_run[i] + 1;
        if (busy_prev[i] !== 1'b1) busy_rise[i] <= cyc;
      end else if (busy_run[i] != 0) begin
        busy_last[i] <= busy_run[i];
        busy_run[i]  <= 0;
        busy_done[i] <= busy_done[i] + 1;
      end
      busy_prev[i] <= busy_w[i];
    end
  end

  // Expected frame length from the frame format.
  function automatic int flen(input int nb, input int p, input int ns);
    return (1 + nb + ((p != 0) ? 1 : 0) + ns) * DIV;
  endfunction

  // Expected parity bit: odd/even refers to the total ones over data plus parity.
  function automatic logic parModel(input logic [8:0] w, input int nb, input int p);
    int ones = 0;
    for (int b = 0; b < nb; b++) ones += int'(w[b]);
    return (p == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  // Reference receiver: finds a start bit, samples every bit at its middle.
  task automatic rx_loop(input int idx, input int nb, input int np, input int ns);
    rx_t f;
    forever begin
      @(negedge clk);
      if (tx_w[idx] === 1'b0) begin
        f.data = '0;
        f.par  = 1'b0;
        f.ok   = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        if (tx_w[idx] !== 1'b0) f.ok = 1'b0;
        for (int b = 0; b < nb; b++) begin
          repeat (DIV) @(negedge clk);
          f.data[b] = tx_w[idx];
        end
        if (np != 0) begin
          repeat (DIV) @(negedge clk);
          f.par = tx_w[idx];
        end
        for (int s = 0; s < ns; s++) begin
          repeat (DIV) @(negedge clk);
          if (tx_w[idx] !== 1'b1) f.ok = 1'b0;
        end
        case (idx)
          0: rx0_q.push_back(f);
          1: rx1_q.push_back(f);
          2: rx2_q.push_back(f);
          default: rx3_q.push_back(f);
        endcase
      end
    end
  endtask

  initial rx_loop(0, 8, 0, 1);
  initial rx_loop(1, 8, 1, 1);
  initial rx_loop(2, 8, 1, 1);
  initial rx_loop(3, 7, 0, 2);

  function automatic int rxSize(input int idx);
    case (idx)
      0: return rx0_q.size();
      1: return rx1_q.size();
      2: return rx2_q.size();
      default: return rx3_q.size();
    endcase
  endfunction

  task automatic getFrame(input int idx, output rx_t f);
    f.data = 'x;
    f.par  = 1'bx;
    f.ok   = 1'b0;
    case (idx)
      0: if (rx0_q.size() != 0) f = rx0_q.pop_front();
      1: if (rx1_q.size() != 0) f = rx1_q.pop_front();
      2: if (rx2_q.size() != 0) f = rx2_q.pop_front();
      default: if (rx3_q.size() != 0) f = rx3_q.pop_front();
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checks++;
    failures++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  // Offers one word to one instance and holds it until accepted.
  task automatic applyStimulus(input int idx, input logic [8:0] w);
    int n;
    @(negedge clk);
    case (idx)
      0: d0 = w[7:0];
      1: d1 = w[7:0];
      2: d2 = w[7:0];
      default: d3 = w[6:0];
    endcase
    v[idx] = 1'b1;
    for (n = 0; n < 50 && rdy[idx] !== 1'b1; n++) @(negedge clk);
    if (rdy[idx] !== 1'b1) timeoutFail("push_accept");
    @(negedge clk);
    v[idx] = 1'b0;
  endtask

  task automatic waitFrames(input int idx, input int n, input int budget);
    for (int i = 0; i < budget && rxSize(idx) < n; i++) @(negedge clk);
    if (rxSize(idx) < n) timeoutFail("frame_wait");
  endtask

  task automatic waitBusyDone(input int idx, input int target, input int budget);
    for (int i = 0; i < budget && busy_done[idx] < target; i++) @(negedge clk);
    if (busy_done[idx] < target) timeoutFail("busy_wait");
  endtask

  initial begin
    rx_t  f;
    int   acc;
    int   bd;
    logic [7:0] exp_q[$];

    rst = 1'b1;
    v   = '0;
    d0  = '0; d1 = '0; d2 = '0; d3 = '0;

    // Reset, with a push offered while reset is held.
    repeat (2) @(negedge clk);
    v[0] = 1'b1;
    d0   = 8'hFF;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    v[0] = 1'b0;
    @(negedge clk);
    checkOutput("reset_tx", tx_w[0], 1);
    checkOutput("reset_busy", busy_w[0], 0);
    checkOutput("reset_count", cnt0, 0);
    checkOutput("reset_ready", rdy[0], 1);

    // Single frames on the parity and 7N2 instances.
    applyStimulus(1, 9'h07);
    applyStimulus(2, 9'h07);
    applyStimulus(2, 9'h00);
    applyStimulus(3, 9'h55);

    // 8N1 0xAA with the idle-to-start latency observed cycle by cycle.
    @(negedge clk);
    d0   = 8'hAA;
    v[0] = 1'b1;
    checkOutput("lat_ready", rdy[0], 1);
    @(negedge clk);
    v[0] = 1'b0;
    checkOutput("lat_count_t", cnt0, 1);
    checkOutput("lat_busy_t", busy_w[0], 0);
    checkOutput("lat_tx_t", tx_w[0], 1);
    @(negedge clk);
    checkOutput("lat_count_t1", cnt0, 0);
    checkOutput("lat_busy_t1", busy_w[0], 1);
    checkOutput("lat_tx_t1", tx_w[0], 0);

    waitFrames(0, 1, 10000);
    waitFrames(1, 1, 10000);
    waitFrames(2, 2, 10000);
    waitFrames(3, 1, 10000);
    getFrame(0, f);
    checkOutput("aa_data", f.data, 9'h0AA);
    checkOutput("aa_ok", f.ok, 1);
    getFrame(1, f);
    checkOutput("even07_data", f.data, 9'h007);
    checkOutput("even07_par", f.par, parModel(9'h007, 8, 2));
    checkOutput("even07_ok", f.ok, 1);
    getFrame(2, f);
    checkOutput("odd07_data", f.data, 9'h007);
    checkOutput("odd07_par", f.par, parModel(9'h007, 8, 1));
    checkOutput("odd07_ok", f.ok, 1);
    getFrame(2, f);
    checkOutput("odd00_data", f.data, 9'h000);
    checkOutput("odd00_par", f.par, parModel(9'h000, 8, 1));
    checkOutput("odd00_ok", f.ok, 1);
    getFrame(3, f);
    checkOutput("7n2_data", f.data, 9'h055);
    checkOutput("7n2_ok", f.ok, 1);

    for (int i = 0; i < 4; i++) waitBusyDone(i, 1, 3000);
    checkOutput("aa_busy_len", busy_last[0], flen(8, 0, 1));
    checkOutput("even_busy_len", busy_last[1], flen(8, 2, 1));
    checkOutput("odd_b2b_busy_len", busy_last[2], 2 * flen(8, 1, 1));
    checkOutput("7n2_busy_len", busy_last[3], flen(7, 0, 2));

    // Hold in_valid with an incrementing pattern until the FIFO refuses.
    bd  = busy_done[0];
    acc = 0;
    @(negedge clk);
    d0   = 8'h00;
    v[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rdy[0] === 1'b1) begin
        acc++;
        @(negedge clk);
        d0 = 8'(acc);
      end else begin
        break;
      end
    end
    v[0] = 1'b0;
    checkOutput("fill_accepted", acc, 17);
    checkOutput("fill_count", cnt0, 16);
    for (int i = 0; i < 3 * flen(8, 0, 1) && rdy[0] !== 1'b1; i++) @(negedge clk);
    checkOutput("ready_after_pop", cyc - busy_rise[0], flen(8, 0, 1));
    waitFrames(0, 17, 18 * flen(8, 0, 1));
    for (int k = 0; k < 17; k++) begin
      getFrame(0, f);
      checkOutput("fill_data", f.data, 9'(k));
      checkOutput("fill_ok", f.ok, 1);
    end
    waitBusyDone(0, bd + 1, 3000);
    checkOutput("fill_busy_len", busy_last[0], 17 * flen(8, 0, 1));

    // Reset during data bit 3 with three words still queued.
    applyStimulus(0, 9'h011);
    applyStimulus(0, 9'h022);
    applyStimulus(0, 9'h033);
    applyStimulus(0, 9'h044);
    for (int i = 0; i < 3000 && cyc < busy_rise[0] + 4 * DIV + DIV / 2; i++) @(negedge clk);
    checkOutput("pre_reset_count", cnt0, 3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_tx", tx_w[0], 1);
    checkOutput("midreset_busy", busy_w[0], 0);
    checkOutput("midreset_count", cnt0, 0);
    checkOutput("midreset_ready", rdy[0], 1);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    rx0_q.delete();
    bd = busy_done[0];
    applyStimulus(0, 9'h03C);
    waitFrames(0, 1, 3000);
    getFrame(0, f);
    checkOutput("post_reset_data", f.data, 9'h03C);
    checkOutput("post_reset_ok", f.ok, 1);
    waitBusyDone(0, bd + 1, 3000);
    checkOutput("post_reset_busy_len", busy_last[0], flen(8, 0, 1));
    repeat (2 * DIV) @(negedge clk);
    checkOutput("post_reset_extra_frames", rx0_q.size(), 0);

    // Random words, queued together so they also go out back to back.
    for (int k = 0; k < 8; k++) exp_q.push_back(8'($urandom_range(0, 255)));
    for (int k = 0; k < 8; k++) applyStimulus(0, {1'b0, exp_q[k]});
    waitFrames(0, 8, 9 * flen(8, 0, 1));
    for (int k = 0; k < 8; k++) begin
      getFrame(0, f);
      checkOutput("rand_data", f.data, {1'b0, exp_q[k]});
      checkOutput("rand_ok", f.ok, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
